// File: rtl/if_id_queue.sv
// Fetch-to-decode FIFO of {pc, instr}: enqueue at edge N is visible on o_d_* after edge N, no F->D bypass.
// o_f_ready comes only from registered occupancy; optional fetch-address check with IFQ_ADEL_EN.
module if_id_queue #(
    parameter int          DEPTH    = 4,
    parameter int          CNT_W    = $clog2(DEPTH + 1),
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_f_valid,
    input  logic [31:0]      i_f_pc,
    input  logic [31:0]      i_f_instr,
    output logic             o_f_ready,
    input  logic             i_flush,
    input  logic             i_d_ready,
    output logic             o_d_valid,
    output logic [31:0]      o_d_pc,
    output logic [31:0]      o_d_instr,
    output logic [CNT_W-1:0] o_count
`ifdef IFQ_ADEL_EN
    ,
    output logic [4:0]       o_d_exc
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      r_pc    [DEPTH];
    logic [31:0]      r_instr [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_enq;
    logic             w_deq;
    logic [31:0]      w_wr_instr;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign o_f_ready = ~w_full;
    assign o_d_valid = ~w_empty;
    assign o_count   = r_count;

    // Flush wins over both sides: the same-cycle fetch is dropped and decode consumes nothing.
    assign w_enq = i_f_valid & o_f_ready & ~i_flush;
    assign w_deq = o_d_valid & i_d_ready & ~i_flush;

`ifdef IFQ_ADEL_EN
    logic [4:0] r_exc [DEPTH];
    logic       w_adel;
    logic [4:0] w_wr_exc;

    // Misaligned or outside the text segment: poison the entry with AdEL and a nop.
    assign w_adel     = (i_f_pc[1:0] != 2'b00) | (i_f_pc < 32'h0000_3000) | (i_f_pc > 32'h0000_6FFC);
    assign w_wr_exc   = w_adel ? 5'd4 : 5'd0;
    assign w_wr_instr = w_adel ? 32'h0 : i_f_instr;
    assign o_d_exc    = w_empty ? 5'd0 : r_exc[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_exc[i] <= 5'd0;
            end
        end else if (w_enq) begin
            r_exc[r_wr_ptr] <= w_wr_exc;
        end
    end
`else
    assign w_wr_instr = i_f_instr;
`endif

    assign o_d_pc    = w_empty ? RESET_PC : r_pc[r_rd_ptr];
    assign o_d_instr = w_empty ? 32'h0    : r_instr[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= 32'h0;
                r_instr[i] <= 32'h0;
            end
        end else if (w_enq) begin
            r_pc[r_wr_ptr]    <= i_f_pc;
            r_instr[r_wr_ptr] <= w_wr_instr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int          DEPTH    = 4;
    localparam int          CNT_W    = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic             clk = 1'b0;
    logic             reset;
    logic             f_valid;
    logic [31:0]      f_pc;
    logic [31:0]      f_instr;
    logic             f_ready;
    logic             flush;
    logic             d_ready;
    logic             d_valid;
    logic [31:0]      d_pc;
    logic [31:0]      d_instr;
    logic [CNT_W-1:0] count;
`ifdef IFQ_ADEL_EN
    logic [4:0]       d_exc;
`endif

    int n_pass  = 0;
    int n_total = 0;

    if_id_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .RESET_PC(RESET_PC)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_f_valid (f_valid),
        .i_f_pc    (f_pc),
        .i_f_instr (f_instr),
        .o_f_ready (f_ready),
        .i_flush   (flush),
        .i_d_ready (d_ready),
        .o_d_valid (d_valid),
        .o_d_pc    (d_pc),
        .o_d_instr (d_instr),
        .o_count   (count)
`ifdef IFQ_ADEL_EN
        ,
        .o_d_exc   (d_exc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        dr;
        logic        fl;
        int          cnt;
        logic        dv;
        logic        fr;
        logic [31:0] hpc;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return ~pc;
    endfunction

    function automatic logic addr_bad(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc > 32'h6FFC);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Drive at the falling edge, let one rising edge happen, return at the next falling edge.
    task automatic step(input logic fv, input logic [31:0] pc, input logic dr, input logic fl);
        f_valid = fv;
        f_pc    = pc;
        f_instr = instr_of(pc);
        d_ready = dr;
        flush   = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: a plain queue of fetched words.
    logic [31:0] mq_pc[$];
    logic [31:0] mq_in[$];
    logic [4:0]  mq_ex[$];
    logic [31:0] popped[$];

    initial begin
        reset = 1'b1; f_valid = 1'b0; f_pc = '0; f_instr = '0; d_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_count",   32'(count), 32'd0);
        chk("reset_d_valid", 32'(d_valid), 32'd0);
        chk("reset_f_ready", 32'(f_ready), 32'd1);
        chk("reset_d_pc",    d_pc, 32'h3000);
        chk("reset_d_instr", d_instr, 32'h0);

        //          fv  pc            dr  fl  cnt dv  fr  head pc
        vecs[0]  = '{1, 32'h3000,     0,  0,  1,  1,  1,  32'h3000};
        vecs[1]  = '{1, 32'h3004,     0,  0,  2,  1,  1,  32'h3000};
        vecs[2]  = '{1, 32'h3008,     0,  0,  3,  1,  1,  32'h3000};
        vecs[3]  = '{1, 32'h300C,     0,  0,  4,  1,  0,  32'h3000};
        vecs[4]  = '{1, 32'h3010,     0,  0,  4,  1,  0,  32'h3000};
        vecs[5]  = '{1, 32'h3010,     1,  0,  3,  1,  1,  32'h3004};
        vecs[6]  = '{1, 32'h3010,     1,  0,  3,  1,  1,  32'h3008};
        vecs[7]  = '{0, 32'h0,        0,  0,  3,  1,  1,  32'h3008};
        vecs[8]  = '{1, 32'h3040,     1,  1,  0,  0,  1,  32'h3000};
        vecs[9]  = '{1, 32'h4000,     0,  0,  1,  1,  1,  32'h4000};
        vecs[10] = '{0, 32'h0,        1,  0,  0,  0,  1,  32'h3000};
        vecs[11] = '{0, 32'h0,        1,  0,  0,  0,  1,  32'h3000};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].fv, vecs[i].pc, vecs[i].dr, vecs[i].fl);
            chk($sformatf("vec%0d_count", i),   32'(count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_d_valid", i), 32'(d_valid), 32'(vecs[i].dv));
            chk($sformatf("vec%0d_f_ready", i), 32'(f_ready), 32'(vecs[i].fr));
            chk($sformatf("vec%0d_d_pc", i),    d_pc, vecs[i].hpc);
            chk($sformatf("vec%0d_d_instr", i), d_instr, vecs[i].dv ? instr_of(vecs[i].hpc) : 32'h0);
        end

        // Stream ten words straight through with decode always ready.
        for (int i = 0; i < 14; i++) begin
            if (d_valid) popped.push_back(d_pc);
            step(i < 10, 32'h3000 + 32'(4 * i), 1'b1, 1'b0);
        end
        chk("stream_n_words", 32'(popped.size()), 32'd10);
        for (int i = 0; i < 10 && i < popped.size(); i++)
            chk($sformatf("stream_pc%0d", i), popped[i], 32'h3000 + 32'(4 * i));

`ifdef IFQ_ADEL_EN
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h3002, 1'b0, 1'b0);
        chk("adel_3002_exc",   32'(d_exc), 32'd4);
        chk("adel_3002_instr", d_instr, 32'h0);
        step(1'b1, 32'h7000, 1'b1, 1'b0);
        chk("adel_7000_exc",   32'(d_exc), 32'd4);
        step(1'b1, 32'h3004, 1'b1, 1'b0);
        chk("adel_3004_exc",   32'(d_exc), 32'd0);
        chk("adel_3004_instr", d_instr, instr_of(32'h3004));
        step(1'b1, 32'h3002, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("adel_flush_exc",  32'(d_exc), 32'd0);
`endif

        // Randomized run against the queue model, starting from a flushed (empty) state.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            logic        fv, dr, fl, rs, m_fr, m_dv;
            logic [31:0] pc;
            m_fr = (mq_pc.size() != DEPTH);
            m_dv = (mq_pc.size() != 0);
            chk("rnd_count",   32'(count), 32'(mq_pc.size()));
            chk("rnd_f_ready", 32'(f_ready), 32'(m_fr));
            chk("rnd_d_valid", 32'(d_valid), 32'(m_dv));
            chk("rnd_d_pc",    d_pc, m_dv ? mq_pc[0] : RESET_PC);
            chk("rnd_d_instr", d_instr, m_dv ? mq_in[0] : 32'h0);
`ifdef IFQ_ADEL_EN
            chk("rnd_d_exc",   32'(d_exc), m_dv ? 32'(mq_ex[0]) : 32'd0);
`endif
            fv = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 29) == 0);
            rs = (c == 200);
            if ($urandom_range(0, 3) == 0) pc = $urandom;
            else pc = 32'h3000 + 32'(4 * $urandom_range(0, 32'hFFF));

            if (rs || fl) begin
                mq_pc.delete(); mq_in.delete(); mq_ex.delete();
            end else begin
                if (m_dv && dr) begin
                    void'(mq_pc.pop_front()); void'(mq_in.pop_front()); void'(mq_ex.pop_front());
                end
                if (fv && m_fr) begin
                    mq_pc.push_back(pc);
`ifdef IFQ_ADEL_EN
                    mq_in.push_back(addr_bad(pc) ? 32'h0 : instr_of(pc));
                    mq_ex.push_back(addr_bad(pc) ? 5'd4 : 5'd0);
`else
                    mq_in.push_back(instr_of(pc));
                    mq_ex.push_back(5'd0);
`endif
                end
            end
            reset = rs;
            step(fv, pc, dr, fl);
            reset = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
